nes_alu: RTL and testbench

- 8-bit 6502-style arithmetic/logic unit for the NES CPU datapath, driven combinationally by the CPU controller (operands from data bus / d_in, mode decoded from IR).
- Computes add, subtract, AND, OR, EOR and shift-right, plus carry, overflow, zero and sign flags.
- Results and flags are registered: one clock of latency, synchronous active-high reset.

---
 rtl/nes_alu_if.sv | 28 ++
 rtl/nes_alu.sv | 118 +++++++++++
 tb/tb_nes_alu.sv | 119 +++++++++++
 3 files changed

// File: rtl/nes_alu_if.sv
// Operand/result bundle between the NES CPU controller and the ALU.
// The controller (master) drives operands and mode; the ALU (slave) returns registered results.
interface nes_alu_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [4:0]       mode;
    logic             carry_in;
    logic             decimal;
    logic [WIDTH-1:0] alu_out;
    logic             carry_out;
    logic             overflow;
    logic             zero;
    logic             sign;

    // No handshake: the ALU samples operands on every rising clk edge and presents
    // the result right after that edge, so a new operation may be issued every cycle.
    modport master (
        output alu_a, alu_b, mode, carry_in, decimal,
        input  alu_out, carry_out, overflow, zero, sign
    );

    modport slave (
        input  alu_a, alu_b, mode, carry_in, decimal,
        output alu_out, carry_out, overflow, zero, sign
    );
endinterface

// File: rtl/nes_alu.sv
// 6502-style 8-bit ALU with registered result and C/V/Z/N flags, one cycle latency.
// Define NES_ALU_DECIMAL_EN to enable packed-BCD ADD/SUB when decimal=1 (2A03 ignores it).
module nes_alu #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    nes_alu_if.slave   bus
);
    typedef enum logic [4:0] {
        MODE_ADD = 5'd0,
        MODE_AND = 5'd1,
        MODE_OR  = 5'd2,
        MODE_EOR = 5'd3,
        MODE_SR  = 5'd4,
        MODE_SUB = 5'd5
    } alu_mode_e;

    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic [WIDTH:0]   sum9, diff9;

    logic [WIDTH-1:0] alu_out_d, alu_out_q;
    logic             carry_d, carry_q;
    logic             overflow_d, overflow_q;
    logic             zero_d, zero_q;
    logic             sign_d, sign_q;

    assign a     = bus.alu_a;
    assign b     = bus.alu_b;
    assign cin   = bus.carry_in;
    assign sum9  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign diff9 = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, cin};

`ifdef NES_ALU_DECIMAL_EN
    logic [4:0] lo_add, hi_add, lo_sub, hi_sub;
    logic       lo_add_c, bcd_add_c, lo_sub_b;

    // Per-nibble decimal adjust; the adjusted nibble keeps only its low 4 bits.
    always_comb begin
        lo_add   = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
        lo_add_c = (lo_add > 5'd9);
        if (lo_add_c) lo_add = lo_add + 5'd6;
        hi_add    = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, lo_add_c};
        bcd_add_c = (hi_add > 5'd9);
        if (bcd_add_c) hi_add = hi_add + 5'd6;

        lo_sub   = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, ~cin};
        lo_sub_b = lo_sub[4];
        if (lo_sub_b) lo_sub = lo_sub - 5'd6;
        hi_sub = {1'b0, a[7:4]} - {1'b0, b[7:4]} - {4'b0, lo_sub_b};
        if (hi_sub[4]) hi_sub = hi_sub - 5'd6;
    end
`else
    logic unused_decimal;
    assign unused_decimal = bus.decimal;
`endif

    always_comb begin
        alu_out_d  = '0;
        carry_d    = 1'b0;
        overflow_d = 1'b0;
        case (bus.mode)
            MODE_ADD: begin
                alu_out_d  = sum9[WIDTH-1:0];
                carry_d    = sum9[WIDTH];
                overflow_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum9[WIDTH-1] != a[WIDTH-1]);
`ifdef NES_ALU_DECIMAL_EN
                if (bus.decimal) begin
                    alu_out_d = {hi_add[3:0], lo_add[3:0]};
                    carry_d   = bcd_add_c;
                end
`endif
            end
            MODE_SUB: begin
                alu_out_d  = diff9[WIDTH-1:0];
                carry_d    = diff9[WIDTH];
                overflow_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff9[WIDTH-1] != a[WIDTH-1]);
`ifdef NES_ALU_DECIMAL_EN
                if (bus.decimal) alu_out_d = {hi_sub[3:0], lo_sub[3:0]};
`endif
            end
            MODE_AND: alu_out_d = a & b;
            MODE_OR:  alu_out_d = a | b;
            MODE_EOR: alu_out_d = a ^ b;
            MODE_SR: begin
                alu_out_d = {cin, a[WIDTH-1:1]};
                carry_d   = a[0];
            end
            default: ;
        endcase
        zero_d = (alu_out_d == '0);
        sign_d = alu_out_d[WIDTH-1];
    end

    // Reset clears every flag, including zero, even though alu_out is 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_out_q  <= '0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            sign_q     <= 1'b0;
        end else begin
            alu_out_q  <= alu_out_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            sign_q     <= sign_d;
        end
    end

    assign bus.alu_out   = alu_out_q;
    assign bus.carry_out = carry_q;
    assign bus.overflow  = overflow_q;
    assign bus.zero      = zero_q;
    assign bus.sign      = sign_q;
endmodule

// File: tb/tb_nes_alu.sv
// Directed-vector bench for nes_alu; honours NES_ALU_DECIMAL_EN for the BCD vectors.
module tb_nes_alu;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    nes_alu_if #(.WIDTH(8)) bus ();

    nes_alu #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] m, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic dec);
        bus.mode     = m;
        bus.alu_a    = a;
        bus.alu_b    = b;
        bus.carry_in = cin;
        bus.decimal  = dec;
    endtask

    // Issue one operation, clock it, and check all five outputs just after the edge.
    task automatic run_op(input string tag, input logic [4:0] m, input logic [7:0] a,
                          input logic [7:0] b, input logic cin, input logic dec,
                          input logic [7:0] e_out, input logic e_c, input logic e_v,
                          input logic e_z, input logic e_n);
        drive(m, a, b, cin, dec);
        @(posedge clk);
        #1;
        check({tag, ".out"}, bus.alu_out, e_out);
        check({tag, ".c"}, {7'd0, bus.carry_out}, {7'd0, e_c});
        check({tag, ".v"}, {7'd0, bus.overflow}, {7'd0, e_v});
        check({tag, ".z"}, {7'd0, bus.zero}, {7'd0, e_z});
        check({tag, ".n"}, {7'd0, bus.sign}, {7'd0, e_n});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive(5'd0, 8'h00, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst.out", bus.alu_out, 8'h00);
        check("rst.c", {7'd0, bus.carry_out}, 8'h00);
        check("rst.v", {7'd0, bus.overflow}, 8'h00);
        check("rst.z", {7'd0, bus.zero}, 8'h00);
        check("rst.n", {7'd0, bus.sign}, 8'h00);
        reset = 1'b0;

        //       tag        mode   a      b      cin   dec   out    C     V     Z     N
        run_op("add_ovf",  5'd0, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("add_wrap", 5'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("add_cin",  5'd0, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("sub_ovf",  5'd5, 8'h50, 8'hB0, 1'b1, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("sub_zero", 5'd5, 8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("sub_brw",  5'd5, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("sub_nocin",5'd5, 8'h10, 8'h01, 1'b0, 1'b0, 8'h0E, 1'b1, 1'b0, 1'b0, 1'b0);
        run_op("and",      5'd1, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("or",       5'd2, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("eor",      5'd3, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'hCC, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("sr_ror",   5'd4, 8'h81, 8'hFF, 1'b1, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op("sr_lsr",   5'd4, 8'h01, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("rsv6",     5'd6, 8'hFF, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("rsv31",    5'd31,8'h80, 8'h80, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op("and_dec",  5'd1, 8'h99, 8'h0F, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back: the OR result must not show until the edge after it is presented.
        run_op("b2b_add",  5'd0, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(5'd2, 8'h0F, 8'hF0, 1'b0, 1'b0);
        #2;
        check("b2b_hold", bus.alu_out, 8'h02);
        @(posedge clk);
        #1;
        check("b2b_or", bus.alu_out, 8'hFF);
        check("b2b_or.n", {7'd0, bus.sign}, 8'h01);

        // Reset wins over an ADD presented on the same edge.
        drive(5'd0, 8'h50, 8'h50, 1'b1, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst2.out", bus.alu_out, 8'h00);
        check("rst2.c", {7'd0, bus.carry_out}, 8'h00);
        check("rst2.v", {7'd0, bus.overflow}, 8'h00);
        check("rst2.z", {7'd0, bus.zero}, 8'h00);
        check("rst2.n", {7'd0, bus.sign}, 8'h00);

`ifdef NES_ALU_DECIMAL_EN
        run_op("bcd_add",  5'd0, 8'h19, 8'h28, 1'b0, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("bcd_wrap", 5'd0, 8'h99, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        run_op("bcd_sub",  5'd5, 8'h42, 8'h15, 1'b1, 1'b1, 8'h27, 1'b1, 1'b0, 1'b0, 1'b0);
`else
        run_op("bin_add",  5'd0, 8'h19, 8'h28, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("bin_wrap", 5'd0, 8'h99, 8'h01, 1'b0, 1'b1, 8'h9A, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("bin_sub",  5'd5, 8'h42, 8'h15, 1'b1, 1'b1, 8'h2D, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
